// File: rtl/l15_anycore_req_arbiter.sv
// Round-robin request arbiter from the anycore icache/dcache onto the single L1.5
// request channel, with one outstanding transaction tracked per requester class.
module l15_anycore_req_arbiter #(
  parameter int PADDR_WIDTH = 40,
  parameter int DATA_SWAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ic_req_val,
  input  logic [PADDR_WIDTH-1:0] ic_req_addr,
  output logic                   ic_req_rdy,
  input  logic                   ld_req_val,
  input  logic [PADDR_WIDTH-1:0] ld_req_addr,
  output logic                   ld_req_rdy,
  input  logic                   st_req_val,
  input  logic [PADDR_WIDTH-1:0] st_req_addr,
  input  logic [63:0]            st_req_data,
  input  logic [2:0]             st_req_size,
  output logic                   st_req_rdy,
  output logic                   l15_req_val,
  output logic [4:0]             l15_req_rqtype,
  output logic [PADDR_WIDTH-1:0] l15_req_address,
  output logic [63:0]            l15_req_data,
  output logic [2:0]             l15_req_size,
  input  logic                   l15_req_ack,
  input  logic                   l15_resp_val,
  input  logic [3:0]             l15_resp_rtntype,
  output logic                   ic_pending,
  output logic                   ld_pending,
  output logic                   st_pending,
  output logic                   err_spurious_resp
);

  localparam logic [4:0] IMISS_RQ  = 5'b10000;
  localparam logic [4:0] LOAD_RQ   = 5'b00000;
  localparam logic [4:0] STORE_RQ  = 5'b00001;
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [1:0]               r_ptr;
  logic [1:0]               w_ptr_next;
  logic [2:0]               r_pend;
  logic [2:0]               w_pend_next;
  logic                     r_err;
  logic                     w_spur;
  logic [4:0]               r_rqtype;
  logic [PADDR_WIDTH-1:0]   r_addr;
  logic [63:0]              r_data;
  logic [2:0]               r_size;
  logic [2:0]               w_elig;
  logic [2:0]               w_grant;
  logic [1:0]               w_o0, w_o1, w_o2;
  logic [4:0]               w_sel_rqtype;
  logic [PADDR_WIDTH-1:0]   w_sel_addr;
  logic [63:0]              w_sel_data;
  logic [2:0]               w_sel_size;
  logic [63:0]              w_st_data_rev;
  logic [63:0]              w_st_data;

  // Class index: 0 = icache, 1 = dcache load, 2 = dcache store.
  assign w_elig = {st_req_val, ld_req_val, ic_req_val} & ~r_pend;

  for (genvar gi = 0; gi < 8; gi++) begin : g_swap
    assign w_st_data_rev[8*gi +: 8] = st_req_data[8*(7-gi) +: 8];
  end
  assign w_st_data = (DATA_SWAP != 0) ? w_st_data_rev : st_req_data;

  always_comb begin
    case (r_ptr)
      2'd1:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
      2'd2:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
      default: begin w_o0 = 2'd0; w_o1 = 2'd1; w_o2 = 2'd2; end
    endcase
  end

  // Gated by rst_n so no requester sees rdy while the block is held in reset.
  always_comb begin
    w_grant = 3'b000;
    if (rst_n && r_state == S_IDLE) begin
      if (w_elig[w_o0])      w_grant[w_o0] = 1'b1;
      else if (w_elig[w_o1]) w_grant[w_o1] = 1'b1;
      else if (w_elig[w_o2]) w_grant[w_o2] = 1'b1;
    end
  end

  always_comb begin
    w_sel_rqtype = LOAD_RQ;
    w_sel_addr   = ld_req_addr;
    w_sel_data   = 64'd0;
    w_sel_size   = 3'b000;
    w_ptr_next   = r_ptr;
    if (w_grant[0]) begin
      w_sel_rqtype = IMISS_RQ;
      w_sel_addr   = ic_req_addr;
      w_ptr_next   = 2'd1;
    end else if (w_grant[1]) begin
      w_ptr_next   = 2'd2;
    end else if (w_grant[2]) begin
      w_sel_rqtype = STORE_RQ;
      w_sel_addr   = st_req_addr;
      w_sel_data   = w_st_data;
      w_sel_size   = st_req_size;
      w_ptr_next   = 2'd0;
    end
  end

  always_comb begin
    w_pend_next = r_pend;
    w_spur      = 1'b0;
    if (l15_resp_val) begin
      case (l15_resp_rtntype)
        IFILL_RET: if (r_pend[0]) w_pend_next[0] = 1'b0; else w_spur = 1'b1;
        LOAD_RET:  if (r_pend[1]) w_pend_next[1] = 1'b0; else w_spur = 1'b1;
        ST_ACK:    if (r_pend[2]) w_pend_next[2] = 1'b0; else w_spur = 1'b1;
        default:   ;
      endcase
    end
    w_pend_next = w_pend_next | w_grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_grant)   w_state_next = S_ISSUE;
      S_ISSUE: if (l15_req_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ic_req_rdy  = w_grant[0];
    ld_req_rdy  = w_grant[1];
    st_req_rdy  = w_grant[2];
    l15_req_val = (r_state == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= 2'd0;
      r_pend   <= 3'b000;
      r_err    <= 1'b0;
      r_rqtype <= 5'd0;
      r_addr   <= '0;
      r_data   <= 64'd0;
      r_size   <= 3'd0;
    end else begin
      r_pend <= w_pend_next;
      r_ptr  <= w_ptr_next;
      if (w_spur) r_err <= 1'b1;
      if (|w_grant) begin
        r_rqtype <= w_sel_rqtype;
        r_addr   <= w_sel_addr;
        r_data   <= w_sel_data;
        r_size   <= w_sel_size;
      end
    end
  end

  assign l15_req_rqtype    = r_rqtype;
  assign l15_req_address   = r_addr;
  assign l15_req_data      = r_data;
  assign l15_req_size      = r_size;
  assign ic_pending        = r_pend[0];
  assign ld_pending        = r_pend[1];
  assign st_pending        = r_pend[2];
  assign err_spurious_resp = r_err;

endmodule

// File: tb/tb_l15_anycore_req_arbiter.sv
// Scoreboard bench: stimulus queues expected L1.5 requests, a negedge monitor
// checks each newly presented request and its stability until ack.
module tb_l15_anycore_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req_val, ld_req_val, st_req_val;
  logic [39:0] ic_req_addr, ld_req_addr, st_req_addr;
  logic [63:0] st_req_data;
  logic [2:0]  st_req_size;
  logic        l15_req_ack, l15_resp_val;
  logic [3:0]  l15_resp_rtntype;

  logic        ic_req_rdy, ld_req_rdy, st_req_rdy, l15_req_val;
  logic [4:0]  l15_req_rqtype;
  logic [39:0] l15_req_address;
  logic [63:0] l15_req_data;
  logic [2:0]  l15_req_size;
  logic        ic_pending, ld_pending, st_pending, err_spurious_resp;

  logic        u1_ic_rdy, u1_ld_rdy, u1_st_rdy, u1_val;
  logic [4:0]  u1_rqtype;
  logic [39:0] u1_addr;
  logic [63:0] u1_data;
  logic [2:0]  u1_size;
  logic        u1_icp, u1_ldp, u1_stp, u1_err;

  always #5 clk = ~clk;

  l15_anycore_req_arbiter #(.PADDR_WIDTH(40), .DATA_SWAP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_val(ic_req_val), .ic_req_addr(ic_req_addr), .ic_req_rdy(ic_req_rdy),
    .ld_req_val(ld_req_val), .ld_req_addr(ld_req_addr), .ld_req_rdy(ld_req_rdy),
    .st_req_val(st_req_val), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_size(st_req_size), .st_req_rdy(st_req_rdy),
    .l15_req_val(l15_req_val), .l15_req_rqtype(l15_req_rqtype),
    .l15_req_address(l15_req_address), .l15_req_data(l15_req_data),
    .l15_req_size(l15_req_size), .l15_req_ack(l15_req_ack),
    .l15_resp_val(l15_resp_val), .l15_resp_rtntype(l15_resp_rtntype),
    .ic_pending(ic_pending), .ld_pending(ld_pending), .st_pending(st_pending),
    .err_spurious_resp(err_spurious_resp)
  );

  l15_anycore_req_arbiter #(.PADDR_WIDTH(40), .DATA_SWAP(0)) dut_noswap (
    .clk(clk), .rst_n(rst_n),
    .ic_req_val(ic_req_val), .ic_req_addr(ic_req_addr), .ic_req_rdy(u1_ic_rdy),
    .ld_req_val(ld_req_val), .ld_req_addr(ld_req_addr), .ld_req_rdy(u1_ld_rdy),
    .st_req_val(st_req_val), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_size(st_req_size), .st_req_rdy(u1_st_rdy),
    .l15_req_val(u1_val), .l15_req_rqtype(u1_rqtype),
    .l15_req_address(u1_addr), .l15_req_data(u1_data),
    .l15_req_size(u1_size), .l15_req_ack(l15_req_ack),
    .l15_resp_val(l15_resp_val), .l15_resp_rtntype(l15_resp_rtntype),
    .ic_pending(u1_icp), .ld_pending(u1_ldp), .st_pending(u1_stp),
    .err_spurious_resp(u1_err)
  );

  typedef struct {
    logic [4:0]  rq;
    logic [39:0] a;
    logic [63:0] d;
    logic [2:0]  sz;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [2:0] rdy_vec();
    return {st_req_rdy, ld_req_rdy, ic_req_rdy};
  endfunction

  // Monitor: pop on each newly presented request; then verify fields hold until ack.
  initial begin
    req_t cur;
    logic prev_val;
    int   n;
    prev_val = 1'b0;
    cur = '{rq: 5'd0, a: 40'd0, d: 64'd0, sz: 3'd0};
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && l15_req_val === 1'b1) begin
        if (!prev_val) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual=%h required=none", l15_req_address);
          end else begin
            cur = exp_q.pop_front();
            $display("req rqtype=%b addr=%h data=%h size=%b", l15_req_rqtype,
                     l15_req_address, l15_req_data, l15_req_size);
            chk("req_rqtype", 64'(l15_req_rqtype), 64'(cur.rq));
            chk("req_addr", 64'(l15_req_address), 64'(cur.a));
            chk("req_data", l15_req_data, cur.d);
            chk("req_size", 64'(l15_req_size), 64'(cur.sz));
          end
        end else begin
          chk("hold_addr", 64'(l15_req_address), 64'(cur.a));
          chk("hold_data", l15_req_data, cur.d);
        end
      end
      prev_val = l15_req_val;
      n = int'(ic_req_rdy) + int'(ld_req_rdy) + int'(st_req_rdy);
      if (n > 0) begin
        chk("rdy_onehot", 64'(n), 64'd1);
        chk("rdy_in_issue", 64'(l15_req_val), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_req_val = 0; ld_req_val = 0; st_req_val = 0;
    ic_req_addr = '0; ld_req_addr = '0; st_req_addr = '0;
    st_req_data = '0; st_req_size = '0;
    l15_req_ack = 0; l15_resp_val = 0; l15_resp_rtntype = 4'b0111;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [4:0] rq, input logic [39:0] a,
                          input logic [63:0] d, input logic [2:0] sz);
    req_t e;
    e.rq = rq; e.a = a; e.d = d; e.sz = sz;
    exp_q.push_back(e);
  endtask

  task automatic wait_rdy(input int cls);
    int n;
    logic [2:0] r;
    n = 0;
    do begin
      @(negedge clk);
      r = rdy_vec();
      n++;
    end while (!r[cls] && n < 20);
    chk("rdy_seen", 64'(r[cls]), 64'd1);
  endtask

  task automatic respond(input logic [3:0] t);
    l15_resp_val = 1'b1;
    l15_resp_rtntype = t;
    tick();
    l15_resp_val = 1'b0;
  endtask

  task automatic issue_one(input int cls, input logic [39:0] a, input logic [63:0] d,
                           input logic [2:0] sz, input logic [4:0] erq,
                           input logic [63:0] ed, input logic [2:0] esz, input bit hold);
    case (cls)
      0: begin ic_req_val = 1; ic_req_addr = a; end
      1: begin ld_req_val = 1; ld_req_addr = a; end
      default: begin st_req_val = 1; st_req_addr = a; st_req_data = d; st_req_size = sz; end
    endcase
    push_exp(erq, a, ed, esz);
    wait_rdy(cls);
    tick();
    if (!hold) begin
      ic_req_val = 0; ld_req_val = 0; st_req_val = 0;
    end
    l15_req_ack = 1'b1;
    tick();
    l15_req_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    logic [3:0] rtn[3];
    logic [39:0] rr_addr[3];
    logic [2:0] r;
    bit saw;
    order = '{0, 1, 2, 0};
    rtn = '{4'b0001, 4'b0000, 4'b0100};
    rr_addr = '{40'h00_1000_0000, 40'h00_2000_0008, 40'h00_3000_0010};

    // Reset values, with a requester asserted during reset.
    do_reset();
    rst_n = 1'b0;
    ic_req_val = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_val", 64'(l15_req_val), 64'd0);
    chk("rst_rdy", 64'(rdy_vec()), 64'd0);
    chk("rst_pend", 64'({st_pending, ld_pending, ic_pending}), 64'd0);
    chk("rst_err", 64'(err_spurious_resp), 64'd0);
    chk("rst_fields", 64'({l15_req_rqtype, l15_req_size}) | 64'(l15_req_address) | l15_req_data, 64'd0);

    // Single load with ack delayed to N+3.
    do_reset();
    ld_req_val = 1'b1;
    ld_req_addr = 40'h00_8000_0040;
    push_exp(5'b00000, 40'h00_8000_0040, 64'd0, 3'b000);
    @(negedge clk);
    chk("ld_rdy_N", 64'(rdy_vec()), 64'b010);
    tick();
    ld_req_val = 1'b0;
    @(negedge clk);
    chk("ld_val_N1", 64'(l15_req_val), 64'd1);
    chk("ld_pend_N1", 64'(ld_pending), 64'd1);
    tick();
    @(negedge clk);
    chk("ld_val_N2", 64'(l15_req_val), 64'd1);
    tick();
    l15_req_ack = 1'b1;
    @(negedge clk);
    chk("ld_val_N3", 64'(l15_req_val), 64'd1);
    tick();
    l15_req_ack = 1'b0;
    @(negedge clk);
    chk("ld_val_N4", 64'(l15_req_val), 64'd0);
    chk("ld_pend_N4", 64'(ld_pending), 64'd1);
    respond(4'b0000);
    @(negedge clk);
    chk("ld_pend_ret", 64'(ld_pending), 64'd0);
    chk("ld_err", 64'(err_spurious_resp), 64'd0);

    // Round-robin with all three requesters held.
    do_reset();
    ic_req_val = 1; ic_req_addr = rr_addr[0];
    ld_req_val = 1; ld_req_addr = rr_addr[1];
    st_req_val = 1; st_req_addr = rr_addr[2];
    st_req_data = 64'h0123456789ABCDEF; st_req_size = 3'b111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        l15_resp_val = 1'b1;
        l15_resp_rtntype = rtn[order[i-1]];
      end
      @(negedge clk);
      r = rdy_vec();
      $display("rr grant %0d rdy=%b", i, r);
      chk("rr_grant", 64'(r), 64'(3'b001 << order[i]));
      case (order[i])
        0: push_exp(5'b10000, rr_addr[0], 64'd0, 3'b000);
        1: push_exp(5'b00000, rr_addr[1], 64'd0, 3'b000);
        default: push_exp(5'b00001, rr_addr[2], 64'hEFCDAB8967452301, 3'b111);
      endcase
      tick();
      l15_resp_val = 1'b0;
      l15_req_ack = 1'b1;
      tick();
      l15_req_ack = 1'b0;
    end
    ic_req_val = 0; ld_req_val = 0; st_req_val = 0;
    respond(4'b0001);
    @(negedge clk);
    chk("rr_pend_clear", 64'({st_pending, ld_pending, ic_pending}), 64'd0);

    // Store byte swap, and pass-through on the DATA_SWAP=0 instance.
    do_reset();
    issue_one(2, 40'h00_4000_0100, 64'h0011223344556677, 3'b011,
              5'b00001, 64'h7766554433221100, 3'b011, 1'b0);
    @(negedge clk);
    chk("noswap_data", u1_data, 64'h0011223344556677);
    chk("noswap_rqtype", 64'(u1_rqtype), 64'b00001);
    chk("st_pend", 64'(st_pending), 64'd1);
    respond(4'b0100);
    @(negedge clk);
    chk("st_pend_ret", 64'(st_pending), 64'd0);
    chk("st_err", 64'(err_spurious_resp), 64'd0);

    // Pending blocks regrant of the same class until its fill returns.
    do_reset();
    issue_one(0, 40'h00_5000_0000, 64'd0, 3'b000, 5'b10000, 64'd0, 3'b000, 1'b1);
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ic_req_rdy) saw = 1'b1;
    end
    chk("ic_blocked", 64'(saw), 64'd0);
    tick();
    ic_req_addr = 40'h00_5000_0040;
    l15_resp_val = 1'b1;
    l15_resp_rtntype = 4'b0001;
    push_exp(5'b10000, 40'h00_5000_0040, 64'd0, 3'b000);
    @(negedge clk);
    chk("ic_rdy_ret_cycle", 64'(ic_req_rdy), 64'd0);
    tick();
    l15_resp_val = 1'b0;
    @(negedge clk);
    chk("ic_regrant", 64'(ic_req_rdy), 64'd1);
    tick();
    ic_req_val = 1'b0;
    l15_req_ack = 1'b1;
    tick();
    l15_req_ack = 1'b0;
    respond(4'b0001);

    // Spurious response is sticky; reset mid-issue drops the request.
    do_reset();
    respond(4'b0100);
    @(negedge clk);
    chk("spur_set", 64'(err_spurious_resp), 64'd1);
    chk("spur_st_pend", 64'(st_pending), 64'd0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("spur_sticky", 64'(err_spurious_resp), 64'd1);
    tick();
    ld_req_val = 1'b1;
    ld_req_addr = 40'h00_6000_0080;
    push_exp(5'b00000, 40'h00_6000_0080, 64'd0, 3'b000);
    wait_rdy(1);
    tick();
    ld_req_val = 1'b0;
    @(negedge clk);
    chk("midrst_issue", 64'(l15_req_val), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_val", 64'(l15_req_val), 64'd0);
    chk("midrst_pend", 64'({st_pending, ld_pending, ic_pending}), 64'd0);
    chk("midrst_err", 64'(err_spurious_resp), 64'd0);
    respond(4'b0000);
    @(negedge clk);
    chk("late_resp_err", 64'(err_spurious_resp), 64'd1);

    // Ignored return type with every class pending.
    do_reset();
    issue_one(0, 40'h00_7000_0000, 64'd0, 3'b000, 5'b10000, 64'd0, 3'b000, 1'b0);
    issue_one(1, 40'h00_7000_0008, 64'd0, 3'b000, 5'b00000, 64'd0, 3'b000, 1'b0);
    issue_one(2, 40'h00_7000_0010, 64'hFFEEDDCCBBAA9988, 3'b010,
              5'b00001, 64'h8899AABBCCDDEEFF, 3'b010, 1'b0);
    respond(4'b0111);
    @(negedge clk);
    chk("intret_pend", 64'({st_pending, ld_pending, ic_pending}), 64'b111);
    chk("intret_err", 64'(err_spurious_resp), 64'd0);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
